// File: rtl/jam_cost_eval.sv
// jam_cost_eval
// Cost evaluator for the JAM (job-assignment) datapath. Each permutation
// handed over by the sorter (worker i -> job perm_i) is priced by sweeping
// the external cost ROM over all 8 workers and summing the entries. The block
// keeps the lowest total of the current run and how many permutations hit it,
// and flags the final result with a one-cycle Valid after the last permutation.
//
// Ports:
//   CLK, RST          clock (rising edge) and synchronous active-high reset
//   start, last       permutation ready / final permutation, sampled in IDLE
//   perm0..perm7      job index for workers 0..7, captured on accepted start
//   W, J              cost ROM worker/job address (0 outside accumulation)
//   Cost              cost ROM read data for (W,J)
//   busy              high whenever the evaluator is not idle
//   eval_done         one-cycle pulse per fully evaluated permutation
//   MinCost           lowest total seen in the current run
//   MatchCount        number of permutations whose total equals MinCost
//   Valid             one-cycle pulse: MinCost/MatchCount are final
//
// Build option:
//   JAM_COST_REG_EN   cost ROM has one cycle of registered read latency; the
//                     accumulation phase is stretched to 9 cycles and Cost is
//                     added one cycle after its address was issued.
module jam_cost_eval #(
   parameter int NW  = 8,
   parameter int CW  = 7,
   parameter int SW  = 10,
   parameter int MCW = 16
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           start,
   input  logic           last,
   input  logic [2:0]     perm0,
   input  logic [2:0]     perm1,
   input  logic [2:0]     perm2,
   input  logic [2:0]     perm3,
   input  logic [2:0]     perm4,
   input  logic [2:0]     perm5,
   input  logic [2:0]     perm6,
   input  logic [2:0]     perm7,
   output logic [2:0]     W,
   output logic [2:0]     J,
   input  logic [CW-1:0]  Cost,
   output logic           busy,
   output logic           eval_done,
   output logic [SW-1:0]  MinCost,
   output logic [MCW-1:0] MatchCount,
   output logic           Valid
);

   typedef enum logic [1:0] {IDLE, ACC, CMP} stateT;

   stateT                  state_q, state_d;
   logic [NW-1:0][2:0]     perm_q, perm_d;
   logic                   last_q, last_d;
   logic [SW-1:0]          sum_q, sum_d;
   logic [2:0]             idx_q, idx_d;
   logic [SW-1:0]          minCost_q, minCost_d;
   logic [MCW-1:0]         matchCount_q, matchCount_d;
   logic                   newRun_q, newRun_d;
   logic                   evalDone_q, evalDone_d;
   logic                   valid_q, valid_d;
`ifdef JAM_COST_REG_EN
   logic                   accValid_q, accValid_d;
   logic                   addrDone_q, addrDone_d;
`endif

   // State register. Everything, including the running minimum, returns to
   // its power-up value on RST so an interrupted run leaves no trace.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         perm_q       <= '0;
         last_q       <= 1'b0;
         sum_q        <= '0;
         idx_q        <= '0;
         minCost_q    <= '1;
         matchCount_q <= '0;
         newRun_q     <= 1'b1;
         evalDone_q   <= 1'b0;
         valid_q      <= 1'b0;
`ifdef JAM_COST_REG_EN
         accValid_q   <= 1'b0;
         addrDone_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         perm_q       <= perm_d;
         last_q       <= last_d;
         sum_q        <= sum_d;
         idx_q        <= idx_d;
         minCost_q    <= minCost_d;
         matchCount_q <= matchCount_d;
         newRun_q     <= newRun_d;
         evalDone_q   <= evalDone_d;
         valid_q      <= valid_d;
`ifdef JAM_COST_REG_EN
         accValid_q   <= accValid_d;
         addrDone_q   <= addrDone_d;
`endif
      end
   end

   // Next-state and ROM address logic. IDLE captures a permutation (and
   // clears the running minimum when a new run begins), ACC walks the ROM one
   // worker per cycle, and CMP folds the finished total into the minimum.
   always_comb begin
      state_d      = state_q;
      perm_d       = perm_q;
      last_d       = last_q;
      sum_d        = sum_q;
      idx_d        = idx_q;
      minCost_d    = minCost_q;
      matchCount_d = matchCount_q;
      newRun_d     = newRun_q;
      evalDone_d   = 1'b0;
      valid_d      = 1'b0;
      W            = 3'd0;
      J            = 3'd0;
`ifdef JAM_COST_REG_EN
      accValid_d   = 1'b0;
      addrDone_d   = addrDone_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               perm_d  = {perm7, perm6, perm5, perm4, perm3, perm2, perm1, perm0};
               last_d  = last;
               sum_d   = '0;
               idx_d   = '0;
               state_d = ACC;
`ifdef JAM_COST_REG_EN
               addrDone_d = 1'b0;
`endif
               if (newRun_q) begin
                  minCost_d    = '1;
                  matchCount_d = '0;
                  newRun_d     = 1'b0;
               end
            end
         end
         ACC: begin
`ifdef JAM_COST_REG_EN
            // Addresses go out in the first 8 cycles; the data for each comes
            // back a cycle later, so accValid trails the address phase and the
            // ninth cycle only drains the last ROM word.
            if (!addrDone_q) begin
               W     = idx_q;
               J     = perm_q[idx_q];
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'(NW - 1)) begin
                  addrDone_d = 1'b1;
               end
            end else begin
               state_d = CMP;
            end
            accValid_d = !addrDone_q;
            if (accValid_q) begin
               sum_d = sum_q + {{(SW - CW){1'b0}}, Cost};
            end
`else
            W     = idx_q;
            J     = perm_q[idx_q];
            sum_d = sum_q + {{(SW - CW){1'b0}}, Cost};
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'(NW - 1)) begin
               state_d = CMP;
            end
`endif
         end
         CMP: begin
            if (sum_q < minCost_q) begin
               minCost_d    = sum_q;
               matchCount_d = {{(MCW - 1){1'b0}}, 1'b1};
            end else if (sum_q == minCost_q) begin
               if (matchCount_q != '1) begin
                  matchCount_d = matchCount_q + {{(MCW - 1){1'b0}}, 1'b1};
               end
            end
            evalDone_d = 1'b1;
            if (last_q) begin
               valid_d  = 1'b1;
               newRun_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy       = (state_q != IDLE);
   assign eval_done  = evalDone_q;
   assign Valid      = valid_q;
   assign MinCost    = minCost_q;
   assign MatchCount = matchCount_q;

endmodule
